// File: rtl/muldiv_seq_ctrl.sv
// Multi-cycle sequencer for the EX-stage multiply/divide unit.
// Stalls the pipeline for a per-op cycle count, then opens the HI/LO write.
module muldiv_seq_ctrl #(
    parameter int         MUL_CYCLES = 32,
    parameter int         DIV_CYCLES = 32,
    parameter int         CNT_W      = 6,
    parameter logic [5:0] F_MULT     = 6'b011000,
    parameter logic [5:0] F_MULTU    = 6'b011001,
    parameter logic [5:0] F_DIV      = 6'b011010,
    parameter logic [5:0] F_DIVU     = 6'b011011,
    parameter logic [5:0] OUT_CODE   = 6'b111111,
    parameter logic [5:0] IDLE_CODE  = 6'b000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] funct,
    input  logic       cancel,
    output logic [5:0] alu_ctrl,
    output logic       op_load,
    output logic       busy,
    output logic       stall,
    output logic       hilo_we,
    output logic       done,
    output logic       illegal
);

    localparam int MAX_N = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    // The RUN counter only has to reach N-1, so 2**CNT_W >= N is enough.
    generate
        if (MUL_CYCLES < 1 || DIV_CYCLES < 1 || MAX_N > (1 << CNT_W)) begin : g_bad_cfg
            $error("muldiv_seq_ctrl: cycle counts must be >=1 and fit CNT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WRITE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [5:0]       r_op;
    logic [5:0]       w_op_next;
    logic [5:0]       r_alu;
    logic [5:0]       w_alu_next;
    logic             r_op_load;
    logic             r_busy;
    logic             r_hilo_we;
    logic             r_illegal;
    logic             w_ill_next;
    logic             w_legal;
    logic             w_is_mul;
    logic             w_last;

    assign w_legal  = (funct == F_MULT) || (funct == F_MULTU) ||
                      (funct == F_DIV)  || (funct == F_DIVU);
    assign w_is_mul = (r_op == F_MULT) || (r_op == F_MULTU);
    assign w_last   = r_cnt == (w_is_mul ? MUL_LAST : DIV_LAST);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_op_next  = r_op;
        w_ill_next = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // Cancel outranks start, so a flushed request raises nothing.
                if (start && !cancel) begin
                    if (w_legal) begin
                        w_next    = S_LOAD;
                        w_op_next = funct;
                    end else begin
                        w_ill_next = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_cnt_next = '0;
                w_next     = cancel ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (cancel) begin
                    w_next     = S_IDLE;
                    w_cnt_next = '0;
                end else if (w_last) begin
                    w_next     = S_WRITE;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_WRITE: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_alu_next = IDLE_CODE;
        unique case (w_next)
            S_IDLE:  w_alu_next = IDLE_CODE;
            S_LOAD:  w_alu_next = w_op_next;
            S_RUN:   w_alu_next = w_op_next;
            S_WRITE: w_alu_next = OUT_CODE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_alu     <= IDLE_CODE;
            r_op_load <= 1'b0;
            r_busy    <= 1'b0;
            r_hilo_we <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_op      <= w_op_next;
            r_alu     <= w_alu_next;
            r_op_load <= w_next == S_LOAD;
            r_busy    <= w_next != S_IDLE;
            r_hilo_we <= w_next == S_WRITE;
            r_illegal <= w_ill_next;
        end
    end

    assign alu_ctrl = r_alu;
    assign op_load  = r_op_load;
    assign busy     = r_busy;
    assign hilo_we  = r_hilo_we;
    assign done     = r_hilo_we;
    assign illegal  = r_illegal;
    assign stall    = r_busy | (start & w_legal);

endmodule
